// File: rtl/alu_result_tracer.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_tracer
// Description : Captures each distinct ALU_result value into a trace buffer,
//               then drains it in order through a request/response port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_tracer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic              arm,
    input  logic              stop,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [1:0]        state
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;

    localparam logic [ADDR_W:0] c_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_ONE  = (ADDR_W+1)'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_last_valid;
    logic [DATA_W-1:0] r_last_value;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_distinct;
    logic w_full;
    logic w_write;
    logic w_read;

    assign w_distinct = !r_last_valid || (ALU_result != r_last_value);
    assign w_full     = (r_count == c_FULL);
    assign w_write    = (r_state == c_CAPTURE) && w_distinct && !w_full;
    assign w_read     = (r_state == c_DRAIN) && rd_req && (r_count != '0);

    // Storage is left uninitialised; only entries counted by r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= ALU_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_last_valid <= 1'b0;
            r_last_value <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (arm) begin
                        r_state      <= c_CAPTURE;
                        r_wr_ptr     <= '0;
                        r_rd_ptr     <= '0;
                        r_count      <= '0;
                        r_overflow   <= 1'b0;
                        r_last_valid <= 1'b0;
                    end
                end
                c_CAPTURE: begin
                    // A dropped value still becomes the comparison reference.
                    if (w_distinct) begin
                        r_last_value <= ALU_result;
                        r_last_valid <= 1'b1;
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                            r_count  <= r_count + c_ONE;
                        end
                    end
                    if (stop) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (w_read) begin
                        r_rd_data  <= r_mem[r_rd_ptr];
                        r_rd_valid <= 1'b1;
                        r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
                        r_count    <= r_count - c_ONE;
                        // Last entry leaves: its strobe coincides with IDLE.
                        if (r_count == c_ONE) begin
                            r_state <= c_IDLE;
                        end
                    end else if (r_count == '0) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_tracer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_tracer
// Description : Scoreboard bench for alu_result_tracer with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_tracer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] ALU_result;
    logic              arm;
    logic              stop;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [1:0]        state;

    alu_result_tracer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ALU_result(ALU_result),
        .arm       (arm),
        .stop      (stop),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .overflow  (overflow),
        .state     (state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: trace contents as a plain queue of values.
    logic [DATA_W-1:0] m_trace [$];
    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] m_last;
    bit                m_have_last;
    bit                m_ovf;
    int                m_state;
    logic [DATA_W-1:0] last_rd;
    bit                mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every response pops the scoreboard; otherwise rd_data must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rd_valid actual=1 expected=0 rd_data=%0h", rd_data);
                end else begin
                    logic [DATA_W-1:0] e;
                    e = sb.pop_front();
                    last_rd = e;
                    if (rd_data !== e) begin
                        failures++;
                        $display("FAIL rd_data actual=%0h expected=%0h", rd_data, e);
                    end
                end
            end else begin
                checks++;
                if (rd_data !== last_rd) begin
                    failures++;
                    $display("FAIL rd_data_hold actual=%0h expected=%0h", rd_data, last_rd);
                end
            end
        end
    end

    task automatic check_status();
        chk("state", 64'(state), 64'(m_state));
        chk("count", 64'(count), 64'(m_trace.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic cycle(input logic a, input logic s, input logic r, input logic [DATA_W-1:0] v);
        arm = a; stop = s; rd_req = r; ALU_result = v; reset = 1'b0;
        @(posedge clk);
        case (m_state)
            0: if (a) begin
                m_trace.delete();
                m_ovf = 1'b0;
                m_have_last = 1'b0;
                m_state = 1;
            end
            1: begin
                if (!m_have_last || v != m_last) begin
                    m_last = v;
                    m_have_last = 1'b1;
                    if (m_trace.size() < DEPTH) m_trace.push_back(v);
                    else m_ovf = 1'b1;
                end
                if (s) m_state = 2;
            end
            default: begin
                if (r && m_trace.size() > 0) begin
                    sb.push_back(m_trace.pop_front());
                    if (m_trace.size() == 0) m_state = 0;
                end else if (m_trace.size() == 0) begin
                    m_state = 0;
                end
            end
        endcase
        #1;
        check_status();
        arm = 1'b0; stop = 1'b0; rd_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; arm = 1'b0; stop = 1'b0; rd_req = 1'b0;
        @(posedge clk);
        m_trace.delete();
        m_state = 0;
        m_ovf = 1'b0;
        m_have_last = 1'b0;
        last_rd = '0;
        #1;
        check_status();
        chk("reset_rd_valid", 64'(rd_valid), 64'(0));
        chk("reset_rd_data", 64'(rd_data), 64'(0));
        reset = 1'b0;
    endtask

    task automatic drain_all(input bit random_req);
        int guard;
        guard = 0;
        while (m_state != 0 && guard < 200) begin
            cycle(1'b0, 1'b0, random_req ? 1'($urandom_range(0, 1)) : 1'b1, $urandom);
            guard++;
        end
        chk("drain_finished", 64'(m_state), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        ALU_result = '0;
        reset = 1'b1; arm = 1'b0; stop = 1'b0; rd_req = 1'b0;
        last_rd = '0; m_last = '0; m_have_last = 1'b0; m_ovf = 1'b0; m_state = 0;
        repeat (2) @(posedge clk);
        do_reset();
        mon_en = 1'b1;

        // 1: repeated values collapse to 5,7,3
        cycle(1, 0, 0, 32'd99);
        cycle(0, 0, 0, 32'd5); cycle(0, 0, 0, 32'd5);
        cycle(0, 0, 0, 32'd7); cycle(0, 0, 0, 32'd7); cycle(0, 0, 0, 32'd7);
        cycle(0, 1, 0, 32'd3);
        chk("t1_count", 64'(count), 64'(3));
        repeat (3) cycle(0, 0, 1, 32'd0);
        chk("t1_idle", 64'(state), 64'(0));

        // 2: overflow after 16 distinct values
        cycle(1, 0, 0, 32'd0);
        for (int i = 1; i <= 20; i++) cycle(0, (i == 20), 0, DATA_W'(i));
        chk("t2_count", 64'(count), 64'(16));
        chk("t2_overflow", 64'(overflow), 64'(1));
        repeat (17) cycle(0, 0, 1, 32'd0);

        // 3: full buffer, repeated last value does not overflow
        cycle(1, 0, 0, 32'd0);
        for (int i = 1; i <= 16; i++) cycle(0, 0, 0, DATA_W'(i));
        for (int i = 0; i < 5; i++) cycle(0, (i == 4), 0, 32'd16);
        chk("t3_overflow", 64'(overflow), 64'(0));
        drain_all(1'b0);

        // 4: stop on the very first sample
        cycle(1, 0, 0, 32'd1);
        cycle(0, 1, 0, 32'd9);
        chk("t4_count", 64'(count), 64'(1));
        drain_all(1'b0);

        // 5: reset mid-drain aborts
        cycle(1, 0, 0, 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, (i == 3), 0, DATA_W'(32'hA0 + i));
        cycle(0, 0, 1, 32'd0); cycle(0, 0, 1, 32'd0);
        do_reset();
        cycle(0, 0, 1, 32'd0); cycle(0, 0, 1, 32'd0);

        // 6: idle pulses ignored, then arm and stop recording a single 0
        cycle(0, 1, 0, 32'd4);
        cycle(0, 0, 1, 32'd4);
        cycle(1, 0, 0, 32'd8);
        cycle(0, 1, 0, 32'd0);
        chk("t6_count", 64'(count), 64'(1));
        drain_all(1'b0);

        // Randomised captures over a small value alphabet to exercise repeats
        for (int run = 0; run < 25; run++) begin
            int len;
            len = $urandom_range(1, 40);
            cycle(1, 0, 0, $urandom);
            for (int i = 0; i < len; i++) begin
                logic [DATA_W-1:0] v;
                v = ($urandom_range(0, 7) == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 5));
                cycle(0, (i == len - 1), 0, v);
            end
            drain_all(1'b1);
            if (run % 8 == 7) do_reset();
        end

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_result_tracer.md
Name: alu_result_tracer

Overview:
- Observes the processor's `ALU_result` output and records each distinct value into a small on-chip trace buffer.
- It is the capture end of the same path the simulation bench drives. The bench drives `clk` and `reset` into `main_module`; this block consumes what comes out.
- Captured entries are read back in order through a one-request/one-response handshake, so results can be checked on hardware without a waveform viewer.
- Instantiated beside `main_module`, sharing its `clk` and `reset`.

Parameters:
- DATA_W, 32, width of `ALU_result` and of each trace entry.
- DEPTH, 16, number of trace entries; must be a power of 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ALU_result  input  DATA_W  processor ALU output, sampled every cycle while capturing.
- arm  input  1  one-cycle pulse; starts a new capture from IDLE.
- stop  input  1  one-cycle pulse; ends capture and enters DRAIN.
- rd_req  input  1  read request, honoured only in DRAIN.
- rd_data  output  DATA_W  oldest unread entry; registered.
- rd_valid  output  1  one-cycle strobe qualifying `rd_data`.
- count  output  ADDR_W+1  number of entries held (0..DEPTH).
- overflow  output  1  sticky; set when a distinct value is dropped because the buffer is full.
- state  output  2  IDLE=0, CAPTURE=1, DRAIN=2.

Behaviour:
- Reset (reset=1 at a rising edge):
  - state=IDLE; wr_ptr=0, rd_ptr=0, count=0.
  - overflow=0, rd_valid=0, rd_data=0.
  - last_valid=0, last_value=0.
  - Buffer contents need not be cleared.
  - Reset applied mid-capture or mid-drain aborts the operation at once; no further `rd_valid`.
- IDLE:
  - `stop` and `rd_req` are ignored.
  - `arm`=1 -> CAPTURE next cycle. On the same edge: wr_ptr=0, rd_ptr=0, count=0, overflow=0, last_valid=0.
  - The `ALU_result` value present in the `arm` cycle is not recorded.
- CAPTURE: each cycle, `ALU_result` is "distinct" when last_valid=0 or `ALU_result` != last_value.
  - Distinct and count<DEPTH: write buffer[wr_ptr]; wr_ptr+1 (wraps mod DEPTH); count+1; last_value=ALU_result; last_valid=1.
  - Distinct and count==DEPTH: value dropped; overflow=1; last_value still updated so a repeated dropped value sets nothing new. overflow stays 1 until the next `arm` or reset.
  - Not distinct: nothing written.
  - `stop`=1 -> DRAIN next cycle. The sample in the `stop` cycle is still processed by the rules above.
  - `arm` is ignored.
- DRAIN:
  - `rd_req`=1 and count>0: next cycle rd_data=buffer[rd_ptr] and rd_valid=1. On the same edge rd_ptr+1 (wraps), count-1.
  - `rd_req`=1 and count==0: ignored; rd_valid stays 0.
  - Back-to-back `rd_req` gives one entry per cycle, 1-cycle latency each.
  - When count is 0 after an edge and no read is pending -> IDLE. The final rd_valid is issued in the same cycle state shows IDLE.
  - `stop` with count==0 reaches DRAIN, then IDLE one cycle later.
  - `arm` and `ALU_result` are ignored.
- rd_valid=0 in every cycle without a read response. rd_data holds its last value between reads.
- Equality compares all DATA_W bits. No arithmetic on the data.
- Pointer wrap: only relevant in that wr_ptr reaches DEPTH-1 then 0 when exactly full. Reads return entries in write order.

Test Plan:
1. Reset, arm, drive ALU_result 5,5,7,7,7,3, then stop; issue rd_req x3. Expect count=3 before reads, then rd_data 5,7,3 with rd_valid one cycle after each request, state returns to IDLE, overflow=0.
2. Arm, drive 20 distinct values 1..20, stop. Expect count=16, overflow=1; reads return 1..16; a 17th rd_req gives no rd_valid.
3. Arm, drive 16 distinct values, then hold 16 for 5 cycles, stop. Expect count=16, overflow=0.
4. Arm, then stop with ALU_result=9 in the same cycle as stop (first sample). Expect 9 recorded, count=1; rd_req -> rd_data=9.
5. Arm, record 4 values, stop, read 2, assert reset. Expect state=0, count=0, rd_valid=0 next cycle; rd_req afterwards is ignored.
6. In IDLE pulse stop and rd_req, then arm and immediately stop with no new value sampled beyond the stop cycle's `0`. Expect the IDLE pulses to have no effect, count=1 (value 0), a normal drain, then IDLE.
